// File: rtl/quyu_pkg.sv
// quyu_pkg: shared constants for the quyu divider scheduler.
//   quyu_state_t : scheduler FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   QUYU_WIDTH   : default operand/result width of the shared divider
package quyu_pkg;

    localparam int unsigned QUYU_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } quyu_state_t;

endpackage

// File: rtl/quyu_sched_if.sv
// quyu_sched_if: request, response and divider-port bundle of quyu_sched.
//   req_valid/req_a/req_b/req_ready : per-requester request channel
//   rsp_*                            : single valid/ready response channel
//   div_a/div_b/div_quot/div_rem     : port to the external combinational divider
//   master : requesters, response consumer and divider side
//   slave  : quyu_sched
// Parameters must match the scheduler instance.
interface quyu_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 7,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;

    logic [WIDTH-1:0]      div_a;
    logic [WIDTH-1:0]      div_b;
    logic [2*WIDTH-1:0]    div_quot;
    logic [2*WIDTH-1:0]    div_rem;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quot;
    logic [WIDTH-1:0]      rsp_rem;
    logic                  rsp_div0;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, div_quot, div_rem,
        input  req_ready, div_a, div_b,
        input  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_div0
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, div_quot, div_rem,
        output req_ready, div_a, div_b,
        output rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_div0
    );
endinterface

// File: rtl/quyu_rr_arb.sv
// quyu_rr_arb: combinational round-robin picker.
//   req_valid : request vector
//   ptr       : highest-priority index for this pick
//   grant     : one-hot winner (zero when nothing requests)
//   idx       : winner index
//   any       : at least one request present
module quyu_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan upward from ptr with wrap; the first set bit wins.
    always_comb begin
        int unsigned     j;
        logic [NREQ-1:0] rot;
        j   = 0;
        rot = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j   = (32'(ptr) + k) % NREQ;
            rot = req_valid >> j;
            if (!any && rot[0]) begin
                any = 1'b1;
                idx = IDW'(j);
            end
        end
        grant = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/quyu_sched.sv
// quyu_sched: shares one external combinational divider between NREQ
// requesters. Round-robin grant in IDLE, operands registered onto the
// divider, SETTLE-cycle wait, then the result is returned with the
// requester ID over a valid/ready response channel. Zero divisors are
// answered locally (quot all ones, rem = dividend) without the divider.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : quyu_sched_if.slave (requests, response, divider port)
//   stat_ops   : completed response handshakes (QUYU_SCHED_STATS_EN only)
//   stat_div0  : completed div0 responses     (QUYU_SCHED_STATS_EN only)
module quyu_sched
    import quyu_pkg::*;
#(
    parameter int unsigned WIDTH  = QUYU_WIDTH,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned IDW    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    quyu_sched_if.slave  bus
`ifdef QUYU_SCHED_STATS_EN
    ,
    output logic [31:0]  stat_ops,
    output logic [15:0]  stat_div0
`endif
);

    localparam int unsigned CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    quyu_state_t      state;
    logic [IDW-1:0]   ptr;
    logic [CNTW-1:0]  cnt;
    logic [NREQ-1:0]  win_grant;
    logic [IDW-1:0]   win_idx;
    logic             win_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             unused_hi;

    quyu_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .grant     (win_grant),
        .idx       (win_idx),
        .any       (win_any)
    );

    // Operands of the current winner.
    assign sel_a = WIDTH'(bus.req_a >> (win_idx * WIDTH));
    assign sel_b = WIDTH'(bus.req_b >> (win_idx * WIDTH));

    // Grant is only offered while idle and out of reset, so nothing is
    // accepted on a cycle whose state update is discarded.
    assign bus.req_ready = (state == IDLE && rst_n) ? win_grant : '0;

    // Divider outputs are double width; only the low half is meaningful.
    assign unused_hi = ^{bus.div_quot[2*WIDTH-1:WIDTH], bus.div_rem[2*WIDTH-1:WIDTH]};

    // Scheduler FSM and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            bus.div_a     <= '0;
            bus.div_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_quot  <= '0;
            bus.rsp_rem   <= '0;
            bus.rsp_div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        ptr        <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                        bus.rsp_id <= win_idx;
                        if (sel_b != '0) begin
                            bus.div_a <= sel_a;
                            bus.div_b <= sel_b;
                            cnt       <= CNTW'(SETTLE - 1);
                            state     <= WAIT;
                        end else begin
                            // divisor zero: answer without the divider
                            bus.rsp_quot  <= '1;
                            bus.rsp_rem   <= sel_a;
                            bus.rsp_div0  <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        bus.rsp_quot  <= bus.div_quot[WIDTH-1:0];
                        bus.rsp_rem   <= bus.div_rem[WIDTH-1:0];
                        bus.rsp_div0  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef QUYU_SCHED_STATS_EN
    // Handshake counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_div0 <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            stat_ops <= stat_ops + 32'd1;
            if (bus.rsp_div0) begin
                stat_div0 <= stat_div0 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_quyu_sched.sv
// tb_quyu_sched: self-checking bench for quyu_sched with a behavioural
// divider at the parent level. Directed scenarios followed by a random
// run checked against a transaction-level round-robin/division model.
module tb_quyu_sched;
    import quyu_pkg::*;

    localparam int unsigned W      = 7;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned IDW    = 2;

    logic clk;
    logic rst_n;

    quyu_sched_if #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) ifc ();

`ifdef QUYU_SCHED_STATS_EN
    logic [31:0] stat_ops;
    logic [15:0] stat_div0;
`endif

    quyu_sched #(
        .WIDTH  (W),
        .NREQ   (NREQ),
        .SETTLE (SETTLE),
        .IDW    (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc.slave)
`ifdef QUYU_SCHED_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_div0 (stat_div0)
`endif
    );

    // Divider model; high halves are junk so truncation is exercised.
    always_comb begin
        ifc.div_quot = {{W{1'b1}}, (ifc.div_b == '0) ? {W{1'b1}} : W'(ifc.div_a / ifc.div_b)};
        ifc.div_rem  = {{W{1'b1}}, (ifc.div_b == '0) ? ifc.div_a : W'(ifc.div_a % ifc.div_b)};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec;
    int bad;
    int m_ptr;
    logic [W-1:0] ra [NREQ];
    logic [W-1:0] rb [NREQ];
    logic [W-1:0] last_da;
    logic [W-1:0] last_db;

    // ---------------- model and drive helpers (no checking) ----------------
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        ra[i] = a;
        rb[i] = b;
        ifc.req_a = {ra[3], ra[2], ra[1], ra[0]};
        ifc.req_b = {rb[3], rb[2], rb[1], rb[0]};
        ifc.req_valid = ifc.req_valid | (NREQ'(1) << i);
    endtask

    task automatic clr(input int i);
        ifc.req_valid = ifc.req_valid & ~(NREQ'(1) << i);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        ifc.req_a = '0;
        ifc.req_b = '0;
        tick();
        tick();
        @(negedge clk);
        vec++;
        if ({ifc.req_ready, ifc.div_a, ifc.div_b} !== '0) begin
            bad++;
            $display("FAIL reset_req_div: got %h want 0", {ifc.req_ready, ifc.div_a, ifc.div_b});
        end
        vec++;
        if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0} !== '0) begin
            bad++;
            $display("FAIL reset_rsp: got %h want 0",
                     {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0});
        end
`ifdef QUYU_SCHED_STATS_EN
        vec++;
        if ({stat_ops, stat_div0} !== '0) begin
            bad++;
            $display("FAIL reset_stats: got %h want 0", {stat_ops, stat_div0});
        end
`endif
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        last_da = '0;
        last_db = '0;
    endtask

    task automatic test_single();
        set_req(0, 7'd100, 7'd7);
        @(negedge clk);
        vec++;
        if (ifc.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_grant: got %b want 0001", ifc.req_ready);
        end
        tick();
        clr(0);
        m_ptr = 1;
        @(negedge clk);
        vec++;
        if ({ifc.rsp_valid, ifc.div_a, ifc.div_b} !== {1'b0, 7'd100, 7'd7}) begin
            bad++;
            $display("FAIL single_wait1: got %h want %h", {ifc.rsp_valid, ifc.div_a, ifc.div_b},
                     {1'b0, 7'd100, 7'd7});
        end
        tick();
        @(negedge clk);
        vec++;
        if (ifc.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_wait2: got %b want 0", ifc.rsp_valid);
        end
        tick();
        @(negedge clk);
        vec++;
        if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0} !==
            {1'b1, 2'd0, 7'd14, 7'd2, 1'b0}) begin
            bad++;
            $display("FAIL single_rsp: got %h want %h",
                     {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0},
                     {1'b1, 2'd0, 7'd14, 7'd2, 1'b0});
        end
        tick();
        last_da = 7'd100;
        last_db = 7'd7;
    endtask

    task automatic test_div0();
        set_req(2, 7'd50, 7'd0);
        @(negedge clk);
        vec++;
        if (ifc.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL div0_grant: got %b want 0100", ifc.req_ready);
        end
        tick();
        clr(2);
        m_ptr = 3;
        @(negedge clk);
        vec++;
        if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0} !==
            {1'b1, 2'd2, 7'd127, 7'd50, 1'b1}) begin
            bad++;
            $display("FAIL div0_rsp: got %h want %h",
                     {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0},
                     {1'b1, 2'd2, 7'd127, 7'd50, 1'b1});
        end
        vec++;
        if ({ifc.div_a, ifc.div_b} !== {last_da, last_db}) begin
            bad++;
            $display("FAIL div0_divport: got %h want %h", {ifc.div_a, ifc.div_b}, {last_da, last_db});
        end
        tick();
    endtask

    task automatic test_round_robin();
        int w;
        logic [17:0] ep;
        rst_n = 1'b0;
        set_req(0, 7'd127, 7'd1);
        set_req(1, 7'd5,   7'd9);
        set_req(2, 7'd64,  7'd8);
        set_req(3, 7'd99,  7'd10);
        ifc.rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        for (int k = 0; k < NREQ; k++) begin
            @(negedge clk);
            w = pick(ifc.req_valid, m_ptr);
            vec++;
            if (ifc.req_ready !== NREQ'(1 << w)) begin
                bad++;
                $display("FAIL rr_grant%0d: got %b want %b", k, ifc.req_ready, NREQ'(1 << w));
            end
            tick();
            clr(w);
            m_ptr = (w + 1) % NREQ;
            repeat (SETTLE) begin
                @(negedge clk);
                vec++;
                if (ifc.rsp_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rr_early%0d: got %b want 0", k, ifc.rsp_valid);
                end
                tick();
            end
            @(negedge clk);
            ep = {1'b1, IDW'(w), W'(ra[w] / rb[w]), W'(ra[w] % rb[w]), 1'b0};
            vec++;
            if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0} !== ep) begin
                bad++;
                $display("FAIL rr_rsp%0d: got %h want %h", k,
                         {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0}, ep);
            end
            tick();
            last_da = ra[w];
            last_db = rb[w];
        end
    endtask

    task automatic test_backpressure();
        set_req(1, 7'd33, 7'd4);
        set_req(3, 7'd10, 7'd0);
        ifc.rsp_ready = 1'b0;
        @(negedge clk);
        vec++;
        if (ifc.req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_grant: got %b want 0010", ifc.req_ready);
        end
        tick();
        clr(1);
        repeat (SETTLE) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        for (int c = 0; c <= 5; c++) begin
            vec++;
            if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0, ifc.req_ready} !==
                {1'b1, 2'd1, 7'd8, 7'd1, 1'b0, 4'b0000}) begin
                bad++;
                $display("FAIL bp_hold%0d: got %h want %h", c,
                         {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0, ifc.req_ready},
                         {1'b1, 2'd1, 7'd8, 7'd1, 1'b0, 4'b0000});
            end
            if (c < 5) begin
                tick();
                @(negedge clk);
            end
        end
        ifc.rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        vec++;
        if ({ifc.rsp_valid, ifc.req_ready} !== {1'b0, 4'b1000}) begin
            bad++;
            $display("FAIL bp_release: got %h want %h", {ifc.rsp_valid, ifc.req_ready}, {1'b0, 4'b1000});
        end
        tick();
        clr(3);
        @(negedge clk);
        vec++;
        if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0} !==
            {1'b1, 2'd3, 7'd127, 7'd10, 1'b1}) begin
            bad++;
            $display("FAIL bp_next: got %h want %h",
                     {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0},
                     {1'b1, 2'd3, 7'd127, 7'd10, 1'b1});
        end
        tick();
        m_ptr = 0;
    endtask

    task automatic test_reset_mid_wait();
        set_req(2, 7'd20, 7'd3);
        @(negedge clk);
        vec++;
        if (ifc.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL rstw_grant: got %b want 0100", ifc.req_ready);
        end
        tick();
        clr(2);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 7'd5, 7'd1);
        set_req(3, 7'd9, 7'd2);
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
        vec++;
        if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0, ifc.div_a, ifc.div_b} !== '0) begin
            bad++;
            $display("FAIL rstw_outputs: got %h want 0",
                     {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0, ifc.div_a, ifc.div_b});
        end
        vec++;
        if (ifc.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rstw_ptr: got %b want 0001", ifc.req_ready);
        end
        tick();
        clr(0);
        repeat (SETTLE) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        vec++;
        if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0} !==
            {1'b1, 2'd0, 7'd5, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL rstw_after: got %h want %h",
                     {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0},
                     {1'b1, 2'd0, 7'd5, 7'd0, 1'b0});
        end
        tick();
    endtask

    task automatic test_random();
        int w;
        int bp;
        int lat;
        int n_hs;
        int n_d0;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [17:0] ep;
        rst_n = 1'b0;
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        last_da = '0;
        last_db = '0;
        n_hs = 0;
        n_d0 = 0;
        for (int op = 0; op < 200; op++) begin
            if (ifc.req_valid == '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if ($urandom_range(0, 1) == 1 || i == NREQ - 1)
                        set_req(i, W'($urandom), ($urandom_range(0, 3) == 0) ? '0 : W'($urandom));
                end
            end
            @(negedge clk);
            w = pick(ifc.req_valid, m_ptr);
            vec++;
            if (ifc.req_ready !== NREQ'(1 << w)) begin
                bad++;
                $display("FAIL rnd_grant op%0d: got %b want %b", op, ifc.req_ready, NREQ'(1 << w));
            end
            ea = ra[w];
            eb = rb[w];
            bp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            lat = (eb == '0) ? 1 : SETTLE + 1;
            tick();
            clr(w);
            m_ptr = (w + 1) % NREQ;
            ifc.rsp_ready = (bp == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (i != w) begin
                    if (!ifc.req_valid[i] && $urandom_range(0, 2) == 0)
                        set_req(i, W'($urandom), ($urandom_range(0, 3) == 0) ? '0 : W'($urandom));
                    else if (ifc.req_valid[i] && $urandom_range(0, 9) == 0)
                        clr(i);
                end
            end
            repeat (lat - 1) begin
                @(negedge clk);
                vec++;
                if ({ifc.rsp_valid, ifc.div_a, ifc.div_b} !== {1'b0, ea, eb}) begin
                    bad++;
                    $display("FAIL rnd_wait op%0d: got %h want %h", op,
                             {ifc.rsp_valid, ifc.div_a, ifc.div_b}, {1'b0, ea, eb});
                end
                tick();
            end
            if (eb == '0) begin
                ep = {1'b1, IDW'(w), {W{1'b1}}, ea, 1'b1};
            end else begin
                ep = {1'b1, IDW'(w), W'(ea / eb), W'(ea % eb), 1'b0};
                last_da = ea;
                last_db = eb;
            end
            for (int c = 0; c <= bp; c++) begin
                @(negedge clk);
                vec++;
                if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0} !== ep ||
                    ifc.req_ready !== '0 || {ifc.div_a, ifc.div_b} !== {last_da, last_db}) begin
                    bad++;
                    $display("FAIL rnd_rsp op%0d c%0d: got %h rdy %b div %h want %h rdy 0 div %h", op, c,
                             {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_quot, ifc.rsp_rem, ifc.rsp_div0},
                             ifc.req_ready, {ifc.div_a, ifc.div_b}, ep, {last_da, last_db});
                end
                if (c == bp) ifc.rsp_ready = 1'b1;
                tick();
            end
            n_hs++;
            if (eb == '0) n_d0++;
        end
        @(negedge clk);
        vec++;
        if (ifc.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rnd_idle: got %b want 0", ifc.rsp_valid);
        end
`ifdef QUYU_SCHED_STATS_EN
        vec++;
        if (stat_ops !== 32'(n_hs)) begin
            bad++;
            $display("FAIL stat_ops: got %0d want %0d", stat_ops, n_hs);
        end
        vec++;
        if (stat_div0 !== 16'(n_d0)) begin
            bad++;
            $display("FAIL stat_div0: got %0d want %0d", stat_div0, n_d0);
        end
`endif
    endtask

    initial begin
        vec = 0;
        bad = 0;
        rst_n = 1'b0;
        ifc.req_valid = '0;
        ifc.req_a = '0;
        ifc.req_b = '0;
        ifc.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_div0();
        test_round_robin();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
